// File: rtl/slc3_pkg.sv
`default_nettype none
// ============================================================================
// Module   : slc3_pkg
// Brief    : SLC-3 controller state encoding, opcodes and mux/ALU encodings.
// Revision : 1.0
// ============================================================================
package slc3_pkg;

    typedef enum logic [4:0] {
        S_HALTED,
        S_F_MAR,
        S_F_RD,
        S_F_CAP,
        S_F_IR,
        S_DECODE,
        S_ADD,
        S_AND,
        S_NOT,
        S_BR,
        S_BR_T,
        S_JMP,
        S_JSR,
        S_JSR_T,
        S_LDR_A,
        S_LDR_RD,
        S_LDR_CAP,
        S_LDR_WB,
        S_STR_A,
        S_STR_D,
        S_STR_WR,
        S_PAUSE1,
        S_PAUSE2
    } state_t;

    localparam logic [3:0] OP_BR    = 4'b0000;
    localparam logic [3:0] OP_ADD   = 4'b0001;
    localparam logic [3:0] OP_JSR   = 4'b0100;
    localparam logic [3:0] OP_AND   = 4'b0101;
    localparam logic [3:0] OP_LDR   = 4'b0110;
    localparam logic [3:0] OP_STR   = 4'b0111;
    localparam logic [3:0] OP_NOT   = 4'b1001;
    localparam logic [3:0] OP_JMP   = 4'b1100;
    localparam logic [3:0] OP_PAUSE = 4'b1101;

    localparam logic [1:0] PCMUX_INC   = 2'b00;
    localparam logic [1:0] PCMUX_BUS   = 2'b01;
    localparam logic [1:0] PCMUX_ADDR  = 2'b10;

    localparam logic [1:0] ADDR2_ZERO   = 2'b00;
    localparam logic [1:0] ADDR2_SEXT6  = 2'b01;
    localparam logic [1:0] ADDR2_SEXT9  = 2'b10;
    localparam logic [1:0] ADDR2_SEXT11 = 2'b11;

    localparam logic [1:0] ALUK_ADD   = 2'b00;
    localparam logic [1:0] ALUK_AND   = 2'b01;
    localparam logic [1:0] ALUK_NOT   = 2'b10;
    localparam logic [1:0] ALUK_PASSA = 2'b11;

endpackage
`default_nettype wire

// File: rtl/slc3_ctrl_fsm.sv
`default_nettype none
// ============================================================================
// Module   : slc3_ctrl_fsm
// Brief    : SLC-3 fetch/decode/execute control FSM with configurable memory
//            wait states or a ready handshake; all controls decode from state.
// Revision : 1.0
// ============================================================================
module slc3_ctrl_fsm
    import slc3_pkg::*;
#(
    parameter int RD_WAIT   = 2,
    parameter int WR_WAIT   = 2,
    parameter int USE_READY = 0
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Run,
    input  logic       Continue,
    input  logic       Mem_Ready,
    input  logic [3:0] Opcode,
    input  logic       IR_5,
    input  logic       IR_11,
    input  logic       BEN,
    output logic       LD_MAR,
    output logic       LD_MDR,
    output logic       LD_IR,
    output logic       LD_BEN,
    output logic       LD_CC,
    output logic       LD_REG,
    output logic       LD_PC,
    output logic       LD_LED,
    output logic       GatePC,
    output logic       GateMDR,
    output logic       GateALU,
    output logic       GateMARMUX,
    output logic [1:0] PCMUX,
    output logic       DRMUX,
    output logic       SR1MUX,
    output logic       SR2MUX,
    output logic       ADDR1MUX,
    output logic [1:0] ADDR2MUX,
    output logic [1:0] ALUK,
    output logic       Mem_OE,
    output logic       Mem_WE,
    output logic       MIO_EN,
    output logic       Illegal_Op
);

    localparam logic [3:0] C_RD_LAST = 4'(RD_WAIT - 1);
    localparam logic [3:0] C_WR_LAST = 4'(WR_WAIT - 1);

    state_t     r_state;
    state_t     w_next;
    logic [3:0] r_wait_cnt;
    logic       r_illegal;
    logic       w_in_wait;
    logic       w_rd_done;
    logic       w_wr_done;
    logic       w_illegal_dec;

    // Counter is zero on the first cycle of every wait state because all
    // wait states are entered from non-wait states.
    assign w_in_wait = (r_state == S_F_RD) || (r_state == S_LDR_RD) || (r_state == S_STR_WR);
    assign w_rd_done = (USE_READY != 0) ? Mem_Ready : (r_wait_cnt == C_RD_LAST);
    assign w_wr_done = (USE_READY != 0) ? Mem_Ready : (r_wait_cnt == C_WR_LAST);

    assign MIO_EN     = Mem_OE;
    assign Illegal_Op = r_illegal;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state    <= S_HALTED;
            r_wait_cnt <= 4'd0;
            r_illegal  <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_wait_cnt <= w_in_wait ? (r_wait_cnt + 4'd1) : 4'd0;
            if (w_illegal_dec) begin
                r_illegal <= 1'b1;
            end
        end
    end

    always_comb begin
        LD_MAR        = 1'b0;
        LD_MDR        = 1'b0;
        LD_IR         = 1'b0;
        LD_BEN        = 1'b0;
        LD_CC         = 1'b0;
        LD_REG        = 1'b0;
        LD_PC         = 1'b0;
        LD_LED        = 1'b0;
        GatePC        = 1'b0;
        GateMDR       = 1'b0;
        GateALU       = 1'b0;
        GateMARMUX    = 1'b0;
        PCMUX         = PCMUX_INC;
        DRMUX         = 1'b0;
        SR1MUX        = 1'b0;
        SR2MUX        = 1'b0;
        ADDR1MUX      = 1'b0;
        ADDR2MUX      = ADDR2_ZERO;
        ALUK          = ALUK_ADD;
        Mem_OE        = 1'b0;
        Mem_WE        = 1'b0;
        w_next        = r_state;
        w_illegal_dec = 1'b0;

        case (r_state)
            S_HALTED: if (Run) w_next = S_F_MAR;
            S_F_MAR: begin
                GatePC = 1'b1;
                LD_MAR = 1'b1;
                LD_PC  = 1'b1;
                PCMUX  = PCMUX_INC;
                w_next = S_F_RD;
            end
            S_F_RD: begin
                Mem_OE = 1'b1;
                if (w_rd_done) w_next = S_F_CAP;
            end
            S_F_CAP: begin
                Mem_OE = 1'b1;
                LD_MDR = 1'b1;
                w_next = S_F_IR;
            end
            S_F_IR: begin
                GateMDR = 1'b1;
                LD_IR   = 1'b1;
                w_next  = S_DECODE;
            end
            S_DECODE: begin
                LD_BEN = 1'b1;
                case (Opcode)
                    OP_ADD:   w_next = S_ADD;
                    OP_AND:   w_next = S_AND;
                    OP_NOT:   w_next = S_NOT;
                    OP_BR:    w_next = S_BR;
                    OP_JMP:   w_next = S_JMP;
                    OP_JSR:   w_next = S_JSR;
                    OP_LDR:   w_next = S_LDR_A;
                    OP_STR:   w_next = S_STR_A;
                    OP_PAUSE: w_next = S_PAUSE1;
                    default: begin
                        w_illegal_dec = 1'b1;
                        w_next        = S_F_MAR;
                    end
                endcase
            end
            S_ADD, S_AND, S_NOT: begin
                SR1MUX  = 1'b1;
                GateALU = 1'b1;
                LD_REG  = 1'b1;
                LD_CC   = 1'b1;
                if (r_state == S_ADD) begin
                    ALUK   = ALUK_ADD;
                    SR2MUX = IR_5;
                end else if (r_state == S_AND) begin
                    ALUK   = ALUK_AND;
                    SR2MUX = IR_5;
                end else begin
                    ALUK   = ALUK_NOT;
                end
                w_next = S_F_MAR;
            end
            S_BR: w_next = BEN ? S_BR_T : S_F_MAR;
            S_BR_T: begin
                PCMUX    = PCMUX_ADDR;
                ADDR2MUX = ADDR2_SEXT9;
                LD_PC    = 1'b1;
                w_next   = S_F_MAR;
            end
            S_JMP: begin
                SR1MUX  = 1'b1;
                ALUK    = ALUK_PASSA;
                GateALU = 1'b1;
                PCMUX   = PCMUX_BUS;
                LD_PC   = 1'b1;
                w_next  = S_F_MAR;
            end
            S_JSR: begin
                DRMUX  = 1'b1;
                GatePC = 1'b1;
                LD_REG = 1'b1;
                w_next = S_JSR_T;
            end
            S_JSR_T: begin
                LD_PC = 1'b1;
                if (IR_11) begin
                    PCMUX    = PCMUX_ADDR;
                    ADDR2MUX = ADDR2_SEXT11;
                end else begin
                    SR1MUX  = 1'b1;
                    ALUK    = ALUK_PASSA;
                    GateALU = 1'b1;
                    PCMUX   = PCMUX_BUS;
                end
                w_next = S_F_MAR;
            end
            S_LDR_A, S_STR_A: begin
                SR1MUX     = 1'b1;
                ADDR1MUX   = 1'b1;
                ADDR2MUX   = ADDR2_SEXT6;
                GateMARMUX = 1'b1;
                LD_MAR     = 1'b1;
                w_next     = (r_state == S_LDR_A) ? S_LDR_RD : S_STR_D;
            end
            S_LDR_RD: begin
                Mem_OE = 1'b1;
                if (w_rd_done) w_next = S_LDR_CAP;
            end
            S_LDR_CAP: begin
                Mem_OE = 1'b1;
                LD_MDR = 1'b1;
                w_next = S_LDR_WB;
            end
            S_LDR_WB: begin
                GateMDR = 1'b1;
                LD_REG  = 1'b1;
                LD_CC   = 1'b1;
                w_next  = S_F_MAR;
            end
            S_STR_D: begin
                ALUK    = ALUK_PASSA;
                GateALU = 1'b1;
                LD_MDR  = 1'b1;
                w_next  = S_STR_WR;
            end
            S_STR_WR: begin
                Mem_WE = 1'b1;
                if (w_wr_done) w_next = S_F_MAR;
            end
            S_PAUSE1: begin
                LD_LED = 1'b1;
                if (Continue) w_next = S_PAUSE2;
            end
            // Wait for release so one press advances exactly one pause.
            S_PAUSE2: if (!Continue) w_next = S_F_MAR;
            default: w_next = S_HALTED;
        endcase
    end

endmodule
`default_nettype wire
